mvm_operand_loader: RTL and testbench

//   Streaming front end for the matrix-vector multiplier.
//   - Accepts one WIDTH-bit element per valid/ready beat and packs each frame into a shadow buffer.
//   - A frame is MATRIX_ROWS*SHARED_DIM matrix elements (row-major), then SHARED_DIM vector elements.
//   - On frame completion the buffer is committed to flat operand buses and start is pulsed.
//   - Next frame loads while the multiplier is busy (double buffered).

---
 rtl/mvm_operand_loader.sv | 141 ++++++++++++++
 tb/tb_mvm_operand_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mvm_operand_loader.sv
// rtl/mvm_operand_loader.sv - double-buffered stream-to-operand loader for the matrix-vector multiplier
module mvm_operand_loader #(
  parameter int MATRIX_ROWS = 6,
  parameter int SHARED_DIM  = 3,
  parameter int WIDTH       = 8
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [WIDTH-1:0]                      in_data,
  input  logic                                  in_valid,
  input  logic                                  in_last,
  output logic                                  in_ready,
  input  logic                                  mvm_done,
  output logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
  output logic [SHARED_DIM*WIDTH-1:0]           vector,
  output logic                                  start,
  output logic                                  busy,
  output logic                                  frame_err
);

  localparam int MS = MATRIX_ROWS * SHARED_DIM;
  localparam int N  = MS + SHARED_DIM;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] M_LAST = IW'(MS - 1);
  localparam logic [IW-1:0] F_LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_M,
    LOAD_V,
    HOLD,
    COMMIT,
    DRAIN
  } state_t;

  state_t                      state;
  logic [IW-1:0]               idx;
  logic [MS*WIDTH-1:0]         shadow_m;
  logic [SHARED_DIM*WIDTH-1:0] shadow_v;
  logic                        beat;

  // Ready is a pure decode of the state register, so no path from in_valid.
  assign in_ready = (state == LOAD_M) || (state == LOAD_V) || (state == DRAIN);
  assign beat     = in_valid && in_ready;

  // Frame sequencing, shadow packing, commit and the busy handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      idx       <= '0;
      shadow_m  <= '0;
      shadow_v  <= '0;
      matrix    <= '0;
      vector    <= '0;
      start     <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      start     <= 1'b0;
      frame_err <= 1'b0;

      // A commit in the same cycle as mvm_done keeps busy set.
      if (state == COMMIT) begin
        busy <= 1'b1;
      end else if (mvm_done) begin
        busy <= 1'b0;
      end

      case (state)
        IDLE: begin
          state <= LOAD_M;
        end

        LOAD_M: begin
          if (beat) begin
            if (in_last) begin
              // Early end of frame: drop the beat and restart at element 0.
              frame_err <= 1'b1;
              idx       <= '0;
            end else begin
              shadow_m[int'(idx)*WIDTH +: WIDTH] <= in_data;
              idx <= idx + 1'b1;
              if (idx == M_LAST) begin
                state <= LOAD_V;
              end
            end
          end
        end

        LOAD_V: begin
          if (beat) begin
            if (idx == F_LAST) begin
              if (in_last) begin
                shadow_v[(int'(idx)-MS)*WIDTH +: WIDTH] <= in_data;
                state <= busy ? HOLD : COMMIT;
              end else begin
                // Frame overran its length: discard until the sender's in_last.
                frame_err <= 1'b1;
                state     <= DRAIN;
              end
            end else if (in_last) begin
              frame_err <= 1'b1;
              idx       <= '0;
              state     <= LOAD_M;
            end else begin
              shadow_v[(int'(idx)-MS)*WIDTH +: WIDTH] <= in_data;
              idx <= idx + 1'b1;
            end
          end
        end

        HOLD: begin
          // The mvm_done that frees the operands also releases the commit.
          if (!busy || mvm_done) begin
            state <= COMMIT;
          end
        end

        COMMIT: begin
          matrix <= shadow_m;
          vector <= shadow_v;
          start  <= 1'b1;
          idx    <= '0;
          state  <= LOAD_M;
        end

        DRAIN: begin
          if (beat && in_last) begin
            idx   <= '0;
            state <= LOAD_M;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mvm_operand_loader.sv
// tb/tb_mvm_operand_loader.sv - scoreboard bench for mvm_operand_loader
module tb_mvm_operand_loader;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         mvm_done;
  logic [143:0] matrix;
  logic [23:0]  vector;
  logic         start;
  logic         busy;
  logic         frame_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int start_count = 0;
  int err_count   = 0;
  int start_cyc   = 0;
  int beat_cyc    = 0;
  logic start_q = 1'b0;
  logic err_q   = 1'b0;
  logic [167:0] sb[$];

  mvm_operand_loader dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mvm_done  (mvm_done),
    .matrix    (matrix),
    .vector    (vector),
    .start     (start),
    .busy      (busy),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pulse widths and scoreboard pops on every start.
  always @(negedge clk) begin
    logic [167:0] e;
    if (start_q) check("start_pulse_width", {191'd0, start}, 192'd0);
    if (err_q) check("err_pulse_width", {191'd0, frame_err}, 192'd0);
    start_q = start;
    err_q   = frame_err;
    if (frame_err) err_count++;
    if (start) begin
      start_count++;
      start_cyc = cyc;
      if (sb.size() == 0) begin
        check("sb_unexpected_start", 192'd1, 192'd0);
      end else begin
        e = sb.pop_front();
        check("sb_matrix", {48'd0, matrix}, {48'd0, e[167:24]});
        check("sb_vector", {168'd0, vector}, {168'd0, e[23:0]});
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input logic l, input bit gaps);
    int n;
    @(negedge clk);
    if (gaps) begin
      for (int g = 0; g < 8 && ($urandom_range(0, 1) == 1); g++) @(negedge clk);
    end
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {191'd0, in_ready}, 192'd1);
    if (in_ready) begin
      @(posedge clk);
      #1;
      beat_cyc = cyc;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Expected operands come from the word sequence: element k is word base+k.
  task automatic send_frame(input logic [7:0] base, input bit gaps);
    logic [143:0] m;
    logic [23:0]  v;
    for (int k = 0; k < 18; k++) m[k*8 +: 8] = base + 8'(k);
    for (int k = 0; k < 3; k++) v[k*8 +: 8] = base + 8'(18 + k);
    sb.push_back({m, v});
    for (int k = 0; k < 21; k++) send_word(base + 8'(k), (k == 20), gaps);
  endtask

  task automatic wait_start(input int prev);
    int n = 0;
    while (start_count <= prev && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("start_timeout", {191'd0, (start_count > prev)}, 192'd1);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    mvm_done = 1'b1;
    @(negedge clk);
    mvm_done = 1'b0;
  endtask

  initial begin
    int s;
    int e;
    logic [143:0] keep_m;
    logic [23:0]  keep_v;
    reset_n  = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    mvm_done = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {191'd0, in_ready}, 192'd0);
    check("rst_start", {191'd0, start}, 192'd0);
    check("rst_busy", {191'd0, busy}, 192'd0);
    check("rst_err", {191'd0, frame_err}, 192'd0);
    check("rst_matrix", {48'd0, matrix}, 192'd0);
    check("rst_vector", {168'd0, vector}, 192'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Frame 1..21, no mvm_done.
    s = start_count;
    send_frame(8'd1, 1'b0);
    wait_start(s);
    // Beat edge, COMMIT edge: start shows after the edge following the beat.
    check("latency", 192'(start_cyc - beat_cyc), 192'd1);
    check("m_first", {184'd0, matrix[7:0]}, 192'd1);
    check("m_last", {184'd0, matrix[143:136]}, 192'd18);
    check("v_first", {184'd0, vector[7:0]}, 192'd19);
    check("v_last", {184'd0, vector[23:16]}, 192'd21);
    check("busy_set", {191'd0, busy}, 192'd1);

    // Second frame while busy must hold until mvm_done.
    s = start_count;
    send_frame(8'd101, 1'b0);
    repeat (4) @(negedge clk);
    check("hold_ready", {191'd0, in_ready}, 192'd0);
    check("hold_matrix", {184'd0, matrix[7:0]}, 192'd1);
    check("hold_no_start", 192'(start_count), 192'(s));
    pulse_done();
    wait_start(s);
    check("second_m0", {184'd0, matrix[7:0]}, 192'd101);
    check("busy_again", {191'd0, busy}, 192'd1);
    pulse_done();
    @(negedge clk);
    check("busy_cleared", {191'd0, busy}, 192'd0);

    // Early in_last on word 10.
    s = start_count;
    e = err_count;
    for (int k = 1; k <= 10; k++) send_word(8'(k), (k == 10), 1'b0);
    repeat (2) @(negedge clk);
    check("early_err", 192'(err_count - e), 192'd1);
    check("early_no_start", 192'(start_count), 192'(s));
    send_frame(8'd201, 1'b0);
    wait_start(s);
    check("early_next_m0", {184'd0, matrix[7:0]}, 192'd201);
    pulse_done();

    // Overlong frame, then drain four words.
    keep_m = matrix;
    keep_v = vector;
    s = start_count;
    e = err_count;
    for (int k = 0; k < 21; k++) send_word(8'd31 + 8'(k), 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("long_err", 192'(err_count - e), 192'd1);
    for (int k = 0; k < 4; k++) send_word(8'd90 + 8'(k), (k == 3), 1'b0);
    repeat (3) @(negedge clk);
    check("drain_err_once", 192'(err_count - e), 192'd1);
    check("drain_no_start", 192'(start_count), 192'(s));
    check("drain_matrix", {48'd0, matrix}, {48'd0, keep_m});
    check("drain_vector", {168'd0, vector}, {168'd0, keep_v});
    send_frame(8'd61, 1'b0);
    wait_start(s);
    pulse_done();

    // Reset mid-frame after word 7.
    for (int k = 0; k < 7; k++) send_word(8'd150 + 8'(k), 1'b0, 1'b0);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("arst_matrix", {48'd0, matrix}, 192'd0);
    check("arst_vector", {168'd0, vector}, 192'd0);
    check("arst_busy", {191'd0, busy}, 192'd0);
    check("arst_ready", {191'd0, in_ready}, 192'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_idle", {191'd0, in_ready}, 192'd0);
    @(negedge clk);
    check("post_rst_load", {191'd0, in_ready}, 192'd1);
    s = start_count;
    send_frame(8'd150, 1'b0);
    wait_start(s);
    check("post_rst_m0", {184'd0, matrix[7:0]}, 192'd150);
    pulse_done();

    // Three frames with random valid gaps.
    e = start_count;
    for (int f = 0; f < 3; f++) begin
      s = start_count;
      send_frame(8'(10 + 30 * f), 1'b1);
      wait_start(s);
      pulse_done();
    end
    repeat (3) @(negedge clk);
    check("gap_starts", 192'(start_count - e), 192'd3);
    check("sb_drained", 192'(sb.size()), 192'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
